xover_ctrl: RTL and testbench

//  Sequencer and coefficient manager for the stereo crossover. Launches one xover_iir instance per

---
 rtl/xover_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_xover_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xover_ctrl.sv
// Stereo crossover sequencer: launches both channel cores per frame, gathers their LPF/HPF results,
// enforces the per-frame cycle budget and owns the shadow/active coefficient set.
module xover_ctrl #(
   parameter int unsigned DATA_W      = 24,
   parameter int unsigned COEFF_W     = 40,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic                  i_mck,
   input  logic                  i_rstn,
   input  logic                  i_frame_valid,
   input  logic [DATA_W-1:0]     i_left,
   input  logic [DATA_W-1:0]     i_right,
   output logic [DATA_W-1:0]     o_core_l_in,
   output logic [DATA_W-1:0]     o_core_r_in,
   output logic                  o_core_start,
   input  logic                  i_core_l_done,
   input  logic                  i_core_r_done,
   input  logic [DATA_W-1:0]     i_core_l_lpf,
   input  logic [DATA_W-1:0]     i_core_l_hpf,
   input  logic [DATA_W-1:0]     i_core_r_lpf,
   input  logic [DATA_W-1:0]     i_core_r_hpf,
   output logic [DATA_W-1:0]     o_left_lpf,
   output logic [DATA_W-1:0]     o_left_hpf,
   output logic [DATA_W-1:0]     o_right_lpf,
   output logic [DATA_W-1:0]     o_right_hpf,
   output logic                  o_frame_valid,
   output logic                  o_busy,
   input  logic                  i_cw_en,
   input  logic [4:0]            i_cw_addr,
   input  logic [COEFF_W-1:0]    i_cw_data,
   input  logic                  i_commit,
   output logic                  o_commit_ack,
   output logic [20*COEFF_W-1:0] o_coeffs,
   output logic                  o_coeff_loaded,
   output logic                  o_err_overrun,
   output logic                  o_err_timeout,
   input  logic                  i_err_clr
);

   localparam int unsigned NumCoeff = 20;
   localparam int unsigned TimerW   = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {StIdle, StWait, StDone, StCommit} state_e;

   state_e                      state_q, state_d;
   logic [TimerW-1:0]           timer_q;
   logic                        done_l_q, done_r_q;
   logic                        cap_l_en, cap_r_en, got_l, got_r;
   logic                        launch, finish, timeout_hit;
   logic [DATA_W-1:0]           cap_l_lpf_q, cap_l_hpf_q, cap_r_lpf_q, cap_r_hpf_q;
   logic [DATA_W-1:0]           cap_l_lpf_d, cap_l_hpf_d, cap_r_lpf_d, cap_r_hpf_d;
   logic [DATA_W-1:0]           core_l_in_q, core_r_in_q;
   logic [DATA_W-1:0]           out_l_lpf_q, out_l_hpf_q, out_r_lpf_q, out_r_hpf_q;
   logic                        core_start_q, commit_ack_q, coeff_loaded_q, pending_q;
   logic                        err_overrun_q, err_timeout_q;
   logic [COEFF_W-1:0]          shadow_q [NumCoeff];
   logic [NumCoeff*COEFF_W-1:0] active_q;

   always_comb begin
      state_d     = state_q;
      launch      = 1'b0;
      timeout_hit = 1'b0;
      // A done pulse in the cycle that completes the frame must reach the outputs directly.
      cap_l_en    = (state_q == StWait) && i_core_l_done;
      cap_r_en    = (state_q == StWait) && i_core_r_done;
      got_l       = done_l_q | cap_l_en;
      got_r       = done_r_q | cap_r_en;
      cap_l_lpf_d = cap_l_en ? i_core_l_lpf : cap_l_lpf_q;
      cap_l_hpf_d = cap_l_en ? i_core_l_hpf : cap_l_hpf_q;
      cap_r_lpf_d = cap_r_en ? i_core_r_lpf : cap_r_lpf_q;
      cap_r_hpf_d = cap_r_en ? i_core_r_hpf : cap_r_hpf_q;
      unique case (state_q)
         StIdle: begin
            if (i_frame_valid) begin
               launch  = 1'b1;
               state_d = StWait;
            end else if (pending_q || i_commit) begin
               state_d = StCommit;
            end
         end
         StWait: begin
            if (got_l && got_r) begin
               state_d = StDone;
            end else if (timer_q == TimerW'(TIMEOUT_CYC)) begin
               timeout_hit = 1'b1;
               state_d     = StDone;
            end
         end
         StDone:   state_d = StIdle;
         StCommit: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
      finish = (state_q == StWait) && (state_d == StDone);
   end

   always_ff @(posedge i_mck) begin
      if (!i_rstn) begin
         state_q        <= StIdle;
         timer_q        <= '0;
         done_l_q       <= 1'b0;
         done_r_q       <= 1'b0;
         cap_l_lpf_q    <= '0;
         cap_l_hpf_q    <= '0;
         cap_r_lpf_q    <= '0;
         cap_r_hpf_q    <= '0;
         core_l_in_q    <= '0;
         core_r_in_q    <= '0;
         out_l_lpf_q    <= '0;
         out_l_hpf_q    <= '0;
         out_r_lpf_q    <= '0;
         out_r_hpf_q    <= '0;
         core_start_q   <= 1'b0;
         commit_ack_q   <= 1'b0;
         coeff_loaded_q <= 1'b0;
         pending_q      <= 1'b0;
         err_overrun_q  <= 1'b0;
         err_timeout_q  <= 1'b0;
         active_q       <= '0;
         for (int unsigned k = 0; k < NumCoeff; k++) begin
            shadow_q[k] <= '0;
         end
      end else begin
         state_q      <= state_d;
         core_start_q <= launch;
         commit_ack_q <= (state_q == StCommit);
         if (launch) begin
            core_l_in_q <= i_left;
            core_r_in_q <= i_right;
            timer_q     <= '0;
            done_l_q    <= 1'b0;
            done_r_q    <= 1'b0;
         end else if (state_q == StWait) begin
            timer_q  <= timer_q + 1'b1;
            done_l_q <= got_l;
            done_r_q <= got_r;
         end
         cap_l_lpf_q <= cap_l_lpf_d;
         cap_l_hpf_q <= cap_l_hpf_d;
         cap_r_lpf_q <= cap_r_lpf_d;
         cap_r_hpf_q <= cap_r_hpf_d;
         // A channel that never finished keeps its previous frame's results.
         if (finish && got_l) begin
            out_l_lpf_q <= cap_l_lpf_d;
            out_l_hpf_q <= cap_l_hpf_d;
         end
         if (finish && got_r) begin
            out_r_lpf_q <= cap_r_lpf_d;
            out_r_hpf_q <= cap_r_hpf_d;
         end
         err_overrun_q <= (i_frame_valid && (state_q != StIdle)) || (err_overrun_q && !i_err_clr);
         err_timeout_q <= timeout_hit || (err_timeout_q && !i_err_clr);
         // A commit arriving during the copy itself stays pending for a second copy.
         pending_q     <= i_commit || (pending_q && (state_q != StCommit));
         if (state_q == StCommit) begin
            for (int unsigned k = 0; k < NumCoeff; k++) begin
               active_q[k*COEFF_W +: COEFF_W] <= shadow_q[k];
            end
            coeff_loaded_q <= 1'b1;
         end
         if (i_cw_en && (i_cw_addr < 5'(NumCoeff))) begin
            shadow_q[i_cw_addr] <= i_cw_data;
         end
      end
   end

   assign o_core_l_in    = core_l_in_q;
   assign o_core_r_in    = core_r_in_q;
   assign o_core_start   = core_start_q;
   assign o_left_lpf     = out_l_lpf_q;
   assign o_left_hpf     = out_l_hpf_q;
   assign o_right_lpf    = out_r_lpf_q;
   assign o_right_hpf    = out_r_hpf_q;
   assign o_frame_valid  = (state_q == StDone);
   assign o_busy         = (state_q != StIdle);
   assign o_commit_ack   = commit_ack_q;
   assign o_coeffs       = active_q;
   assign o_coeff_loaded = coeff_loaded_q;
   assign o_err_overrun  = err_overrun_q;
   assign o_err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_xover_ctrl.sv
// Self-checking bench for xover_ctrl: timestamp-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_xover_ctrl;
   localparam int DW = 24;
   localparam int CW = 40;
   localparam int TO = 255;
   localparam int NC = 20;

   logic i_mck = 1'b0;
   always #5 i_mck = ~i_mck;

   logic              i_rstn, i_frame_valid, i_core_l_done, i_core_r_done;
   logic [DW-1:0]     i_left, i_right, i_core_l_lpf, i_core_l_hpf, i_core_r_lpf, i_core_r_hpf;
   logic              i_cw_en, i_commit, i_err_clr;
   logic [4:0]        i_cw_addr;
   logic [CW-1:0]     i_cw_data;
   logic [DW-1:0]     o_core_l_in, o_core_r_in, o_left_lpf, o_left_hpf, o_right_lpf, o_right_hpf;
   logic              o_core_start, o_frame_valid, o_busy, o_commit_ack, o_coeff_loaded;
   logic              o_err_overrun, o_err_timeout;
   logic [NC*CW-1:0]  o_coeffs;

   xover_ctrl #(.DATA_W(DW), .COEFF_W(CW), .TIMEOUT_CYC(TO)) dut (
      .i_mck(i_mck), .i_rstn(i_rstn), .i_frame_valid(i_frame_valid),
      .i_left(i_left), .i_right(i_right),
      .o_core_l_in(o_core_l_in), .o_core_r_in(o_core_r_in), .o_core_start(o_core_start),
      .i_core_l_done(i_core_l_done), .i_core_r_done(i_core_r_done),
      .i_core_l_lpf(i_core_l_lpf), .i_core_l_hpf(i_core_l_hpf),
      .i_core_r_lpf(i_core_r_lpf), .i_core_r_hpf(i_core_r_hpf),
      .o_left_lpf(o_left_lpf), .o_left_hpf(o_left_hpf),
      .o_right_lpf(o_right_lpf), .o_right_hpf(o_right_hpf),
      .o_frame_valid(o_frame_valid), .o_busy(o_busy),
      .i_cw_en(i_cw_en), .i_cw_addr(i_cw_addr), .i_cw_data(i_cw_data),
      .i_commit(i_commit), .o_commit_ack(o_commit_ack), .o_coeffs(o_coeffs),
      .o_coeff_loaded(o_coeff_loaded), .o_err_overrun(o_err_overrun),
      .o_err_timeout(o_err_timeout), .i_err_clr(i_err_clr)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int fv_count = 0;
   bit model_ok = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got %h exp %h", name, cyc, act, exp);
      end
   endtask

   // Reference model: the frame in flight is described by its launch cycle and the cycle its
   // result frame is due; a commit by the cycle the copy happens.
   int            m_launch, m_done_at, m_commit_at;
   bit            m_seen_l, m_seen_r, m_pending;
   logic [DW-1:0] m_cap [4];
   logic [DW-1:0] m_out [4];
   logic [DW-1:0] m_core_l, m_core_r;
   logic [CW-1:0] m_shadow [NC];
   logic [CW-1:0] m_active [NC];
   bit            e_start, e_fv, e_busy, e_ack, e_loaded, e_ovr, e_to;

   function automatic void model_reset();
      m_launch = -1; m_done_at = -1; m_commit_at = -1;
      m_seen_l = 0; m_seen_r = 0; m_pending = 0;
      m_core_l = '0; m_core_r = '0;
      for (int k = 0; k < 4; k++) begin m_cap[k] = '0; m_out[k] = '0; end
      for (int k = 0; k < NC; k++) begin m_shadow[k] = '0; m_active[k] = '0; end
      e_start = 0; e_fv = 0; e_busy = 0; e_ack = 0; e_loaded = 0; e_ovr = 0; e_to = 0;
   endfunction

   function automatic void model_step();
      int t;
      bit waiting, idle, new_to, accepted;
      t        = cyc;
      waiting  = (m_launch >= 0) && (m_done_at < 0);
      idle     = !waiting && (t != m_done_at) && (t != m_commit_at);
      new_to   = 0;
      accepted = 0;
      if (t == m_done_at) begin m_launch = -1; m_done_at = -1; end
      e_ack = (t == m_commit_at);
      if (t == m_commit_at) begin
         m_active    = m_shadow;
         e_loaded    = 1;
         m_pending   = i_commit;
         m_commit_at = -1;
      end else begin
         m_pending = m_pending | i_commit;
      end
      if (waiting) begin
         if (i_core_l_done) begin m_seen_l = 1; m_cap[0] = i_core_l_lpf; m_cap[1] = i_core_l_hpf; end
         if (i_core_r_done) begin m_seen_r = 1; m_cap[2] = i_core_r_lpf; m_cap[3] = i_core_r_hpf; end
         if ((m_seen_l && m_seen_r) || (t - m_launch == TO)) begin
            m_done_at = t + 1;
            new_to    = !(m_seen_l && m_seen_r);
            if (m_seen_l) begin m_out[0] = m_cap[0]; m_out[1] = m_cap[1]; end
            if (m_seen_r) begin m_out[2] = m_cap[2]; m_out[3] = m_cap[3]; end
         end
      end else if (idle) begin
         if (i_frame_valid) begin
            accepted = 1;
            m_launch = t + 1;
            m_seen_l = 0;
            m_seen_r = 0;
            m_core_l = i_left;
            m_core_r = i_right;
         end else if (m_pending) begin
            m_commit_at = t + 1;
         end
      end
      e_ovr = (i_frame_valid && !idle) || (e_ovr && !i_err_clr);
      e_to  = new_to || (e_to && !i_err_clr);
      if (i_cw_en && (i_cw_addr < NC)) m_shadow[i_cw_addr] = i_cw_data;
      e_start = accepted;
      e_fv    = (m_done_at == t + 1);
      e_busy  = ((m_launch >= 0) && (m_done_at < 0)) || e_fv || (m_commit_at == t + 1);
   endfunction

   always @(posedge i_mck) begin
      if (!i_rstn) begin
         model_reset();
         model_ok = 1;
      end else if (model_ok) begin
         model_step();
      end
      cyc++;
   end

   logic [NC*CW-1:0] exp_c;
   always @(negedge i_mck) begin
      if (model_ok) begin
         chk("core_start", o_core_start, e_start);
         chk("frame_valid", o_frame_valid, e_fv);
         chk("busy", o_busy, e_busy);
         chk("commit_ack", o_commit_ack, e_ack);
         chk("coeff_loaded", o_coeff_loaded, e_loaded);
         chk("err_overrun", o_err_overrun, e_ovr);
         chk("err_timeout", o_err_timeout, e_to);
         chk("core_l_in", o_core_l_in, m_core_l);
         chk("core_r_in", o_core_r_in, m_core_r);
         chk("left_lpf", o_left_lpf, m_out[0]);
         chk("left_hpf", o_left_hpf, m_out[1]);
         chk("right_lpf", o_right_lpf, m_out[2]);
         chk("right_hpf", o_right_hpf, m_out[3]);
         for (int k = 0; k < NC; k++) exp_c[k*CW +: CW] = m_active[k];
         checks++;
         if (o_coeffs !== exp_c) begin
            errors++;
            $display("FAIL coeffs cyc=%0d got %h exp %h", cyc, o_coeffs, exp_c);
         end
      end
   end

   always @(negedge i_mck) if (o_frame_valid === 1'b1) fv_count++;

   logic [DW-1:0] dv [4];

   task automatic cycle_end();
      @(posedge i_mck);
      #1;
      i_frame_valid = 0; i_core_l_done = 0; i_core_r_done = 0;
      i_cw_en = 0; i_commit = 0; i_err_clr = 0;
   endtask

   // Frame at step 0, launch at step 1, core dones at 1+dl / 1+dr (negative: never).
   task automatic do_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int dl,
                           input int dr, input int ovr_at, input int cmt_at, output int fv_i,
                           output logic [CW-1:0] c7_fv, output logic st, output logic [DW-1:0] cin);
      int last;
      last  = (dl < 0 || dr < 0) ? TO + 4 : ((dl > dr) ? dl : dr) + 4;
      fv_i  = -1;
      c7_fv = '0;
      st    = 0;
      cin   = '0;
      for (int i = 0; i <= last; i++) begin
         if (i == 0) begin i_frame_valid = 1; i_left = l; i_right = r; end
         if (i == ovr_at) begin i_frame_valid = 1; i_left = ~l; i_right = ~r; end
         if (dl >= 0 && i == 1 + dl) begin
            i_core_l_done = 1; i_core_l_lpf = dv[0]; i_core_l_hpf = dv[1];
         end
         if (dr >= 0 && i == 1 + dr) begin
            i_core_r_done = 1; i_core_r_lpf = dv[2]; i_core_r_hpf = dv[3];
         end
         if (i == cmt_at) begin
            i_cw_en = 1; i_cw_addr = 5'd7; i_cw_data = 40'hABCDE; i_commit = 1;
         end
         cycle_end();
         if (i == 0) begin st = o_core_start; cin = o_core_l_in; end
         if (o_frame_valid === 1'b1 && fv_i < 0) begin
            fv_i  = i + 1;
            c7_fv = o_coeffs[7*CW +: CW];
         end
      end
   endtask

   int            fvi, fv0;
   logic [CW-1:0] c7;
   logic          st;
   logic [DW-1:0] cin;

   initial begin
      i_rstn = 0; i_frame_valid = 0; i_left = '0; i_right = '0;
      i_core_l_done = 0; i_core_r_done = 0;
      i_core_l_lpf = '0; i_core_l_hpf = '0; i_core_r_lpf = '0; i_core_r_hpf = '0;
      i_cw_en = 0; i_cw_addr = '0; i_cw_data = '0; i_commit = 0; i_err_clr = 0;
      repeat (3) cycle_end();
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_coeffs_lo", o_coeffs[63:0], 64'd0);
      i_rstn = 1;
      cycle_end();

      // Load k+1 into every shadow slot; the last write shares its cycle with the commit.
      for (int k = 0; k < NC; k++) begin
         i_cw_en = 1; i_cw_addr = 5'(k); i_cw_data = CW'(k + 1);
         if (k == NC - 1) i_commit = 1;
         cycle_end();
      end
      chk("t1_loaded_before", o_coeff_loaded, 1'b0);
      chk("t1_busy_commit", o_busy, 1'b1);
      cycle_end();
      chk("t1_ack", o_commit_ack, 1'b1);
      chk("t1_loaded", o_coeff_loaded, 1'b1);
      chk("t1_c0", o_coeffs[0 +: CW], 64'd1);
      chk("t1_c6", o_coeffs[6*CW +: CW], 64'd7);
      chk("t1_c19", o_coeffs[19*CW +: CW], 64'd20);
      cycle_end();

      dv[0] = 24'h111111; dv[1] = 24'h222222; dv[2] = 24'h333333; dv[3] = 24'h444444;
      fv0 = fv_count;
      do_frame(24'h100000, 24'hF00000, 29, 31, -1, -1, fvi, c7, st, cin);
      chk("t2_start", st, 1'b1);
      chk("t2_core_l_in", cin, 64'h100000);
      chk("t2_fv_step", fvi, 64'd33);
      chk("t2_fv_count", fv_count - fv0, 64'd1);
      chk("t2_left_lpf", o_left_lpf, 64'h111111);
      chk("t2_left_hpf", o_left_hpf, 64'h222222);
      chk("t2_right_lpf", o_right_lpf, 64'h333333);
      chk("t2_right_hpf", o_right_hpf, 64'h444444);

      dv[0] = 24'h555555; dv[1] = 24'h666666; dv[2] = 24'h777777; dv[3] = 24'h888888;
      fv0 = fv_count;
      do_frame(24'h012345, 24'h0ABCDE, 29, 31, 10, -1, fvi, c7, st, cin);
      chk("t3_overrun", o_err_overrun, 1'b1);
      chk("t3_fv_count", fv_count - fv0, 64'd1);
      chk("t3_right_hpf", o_right_hpf, 64'h888888);
      i_err_clr = 1;
      cycle_end();
      chk("t3_overrun_clr", o_err_overrun, 1'b0);

      dv[0] = 24'h999999; dv[1] = 24'hAAAAAA; dv[2] = 24'hBBBBBB; dv[3] = 24'hCCCCCC;
      fv0 = fv_count;
      do_frame(24'h000001, 24'h000002, 20, -1, -1, -1, fvi, c7, st, cin);
      chk("t4_timeout", o_err_timeout, 1'b1);
      chk("t4_fv_step", fvi, 64'(TO + 2));
      chk("t4_fv_count", fv_count - fv0, 64'd1);
      chk("t4_left_lpf", o_left_lpf, 64'h999999);
      chk("t4_right_lpf_held", o_right_lpf, 64'h777777);
      chk("t4_right_hpf_held", o_right_hpf, 64'h888888);
      i_err_clr = 1;
      cycle_end();
      chk("t4_timeout_clr", o_err_timeout, 1'b0);

      dv[0] = 24'h123456; dv[1] = 24'h234567; dv[2] = 24'h345678; dv[3] = 24'h456789;
      do_frame(24'h0F0F0F, 24'h0E0E0E, 29, 31, -1, 5, fvi, c7, st, cin);
      chk("t5_c7_at_done", c7, 64'd8);
      chk("t5_ack", o_commit_ack, 1'b1);
      chk("t5_c7_new", o_coeffs[7*CW +: CW], 64'hABCDE);
      chk("t5_c6_kept", o_coeffs[6*CW +: CW], 64'd7);
      cycle_end();

      fv0 = fv_count;
      i_frame_valid = 1; i_left = 24'h0C0C0C; i_right = 24'h0D0D0D;
      cycle_end();
      i_commit = 1;
      repeat (5) cycle_end();
      chk("t6_busy_wait", o_busy, 1'b1);
      i_rstn = 0;
      cycle_end();
      i_rstn = 1;
      chk("t6_busy", o_busy, 1'b0);
      chk("t6_left_lpf", o_left_lpf, 64'd0);
      chk("t6_core_l_in", o_core_l_in, 64'd0);
      chk("t6_loaded", o_coeff_loaded, 1'b0);
      for (int i = 0; i < 4; i++) begin
         i_core_l_done = 1; i_core_r_done = 1;
         cycle_end();
      end
      chk("t6_no_fv", fv_count - fv0, 64'd0);
      chk("t6_still_idle", o_busy, 1'b0);

      for (int n = 0; n < 4000; n++) begin
         i_rstn        = ($urandom_range(0, 799) != 0);
         i_frame_valid = ($urandom_range(0, 39) == 0);
         i_left        = DW'($urandom);
         i_right       = DW'($urandom);
         i_core_l_done = ($urandom_range(0, 24) == 0);
         i_core_r_done = ($urandom_range(0, 24) == 0);
         i_core_l_lpf  = DW'($urandom);
         i_core_l_hpf  = DW'($urandom);
         i_core_r_lpf  = DW'($urandom);
         i_core_r_hpf  = DW'($urandom);
         i_cw_en       = ($urandom_range(0, 3) == 0);
         i_cw_addr     = 5'($urandom_range(0, 23));
         i_cw_data     = CW'({$urandom, $urandom});
         i_commit      = ($urandom_range(0, 29) == 0);
         i_err_clr     = ($urandom_range(0, 49) == 0);
         cycle_end();
      end
      i_rstn = 1;
      repeat (5) cycle_end();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
